pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_pkg.sv | 32 +++
 rtl/load_use_detect.sv | 21 ++
 rtl/pipeline_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline hazard controller: register index width,
// FSM state encoding and the bundle of stage-register control outputs.
package pipeline_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } ctrl_state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic exmem_write;
        logic ifid_flush;
        logic idex_flush;
    } ctrl_out_t;

    localparam ctrl_out_t CTRL_DEFAULT = '{
        pc_write:    1'b1,
        ifid_write:  1'b1,
        idex_write:  1'b1,
        exmem_write: 1'b1,
        ifid_flush:  1'b0,
        idex_flush:  1'b0
    };

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the load in EX and the
// instruction in ID. x0 is hardwired, so a load to it never stalls.
module load_use_detect
    import pipeline_pkg::*;
(
    input  logic [REG_W-1:0] ifid_rs1,
    input  logic [REG_W-1:0] ifid_rs2,
    input  logic             ifid_use_rs2,
    input  logic [REG_W-1:0] idex_rd,
    input  logic             idex_mem_read,
    output logic             hazard
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = (idex_rd == ifid_rs1);
    assign rs2_match = ifid_use_rs2 && (idex_rd == ifid_rs2);
    assign hazard    = idex_mem_read && (idex_rd != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: Mealy stall/flush/freeze control for a 5-stage
// pipeline, with saturating stall/flush counters and a sticky memory timeout.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] IFID_rs1,
    input  logic [REG_W-1:0] IFID_rs2,
    input  logic             IFID_use_rs2,
    input  logic [REG_W-1:0] IDEX_rd,
    input  logic             IDEX_MemRead,
    input  logic             EX_branch_taken,
    input  logic             dmem_busy,
    output logic             PC_write,
    output logic             IFID_write,
    output logic             IDEX_write,
    output logic             EXMEM_write,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    ctrl_state_e      state_q, state_d;
    ctrl_state_e      resume_q, resume_d;
    ctrl_state_e      eval_state;
    ctrl_out_t        ctrl;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [WAIT_W:0]  wait_inc;
    logic             timeout_hit;
    logic             mem_timeout_q, mem_timeout_d;
    logic             lu_hazard;
    logic             flush_inc;
    logic             stall_inc;

    load_use_detect u_lu (
        .ifid_rs1      (IFID_rs1),
        .ifid_rs2      (IFID_rs2),
        .ifid_use_rs2  (IFID_use_rs2),
        .idex_rd       (IDEX_rd),
        .idex_mem_read (IDEX_MemRead),
        .hazard        (lu_hazard)
    );

    // A release from MEM_WAIT replays the frozen cycle as the saved state.
    assign eval_state = (state_q == MEM_WAIT) ? resume_q : state_q;

    always_comb begin
        ctrl      = CTRL_DEFAULT;
        state_d   = state_q;
        resume_d  = resume_q;
        flush_inc = 1'b0;
        if (reset) begin
            state_d = RUN;
        end else if (dmem_busy) begin
            ctrl = '0;
            if (state_q != MEM_WAIT) begin
                resume_d = state_q;
                state_d  = MEM_WAIT;
            end
        end else begin
            case (eval_state)
                RUN: begin
                    if (EX_branch_taken) begin
                        ctrl.ifid_flush = 1'b1;
                        ctrl.idex_flush = 1'b1;
                        flush_inc       = 1'b1;
                        state_d         = FLUSH;
                    end else if (lu_hazard) begin
                        ctrl.pc_write   = 1'b0;
                        ctrl.ifid_write = 1'b0;
                        ctrl.idex_flush = 1'b1;
                        state_d         = LU_STALL;
                    end else begin
                        state_d = RUN;
                    end
                end
                // EX holds a bubble here, so branch and hazard inputs are stale.
                default: state_d = RUN;
            endcase
        end
    end

    assign stall_inc = !reset && !ctrl.pc_write;

    always_comb begin
        stall_cycles_d = stall_cycles_q + CNT_W'(stall_inc && (stall_cycles_q != '1));
        flush_count_d  = flush_count_q + CNT_W'(flush_inc && (flush_count_q != '1));
    end

    // wait_cnt saturates at MEM_TIMEOUT so a long freeze cannot wrap it.
    always_comb begin
        wait_inc      = {1'b0, wait_cnt_q} + 1'b1;
        timeout_hit   = dmem_busy && (wait_inc >= (WAIT_W + 1)'(MEM_TIMEOUT));
        wait_cnt_d    = '0;
        if (dmem_busy) begin
            wait_cnt_d = timeout_hit ? WAIT_W'(MEM_TIMEOUT) : wait_inc[WAIT_W-1:0];
        end
        mem_timeout_d = mem_timeout_q || timeout_hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            resume_q       <= RUN;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
            wait_cnt_q     <= '0;
            mem_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            resume_q       <= resume_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
        end
    end

    assign PC_write     = ctrl.pc_write;
    assign IFID_write   = ctrl.ifid_write;
    assign IDEX_write   = ctrl.idex_write;
    assign EXMEM_write  = ctrl.exmem_write;
    assign IFID_flush   = ctrl.ifid_flush;
    assign IDEX_flush   = ctrl.idex_flush;
    assign ctrl_state   = state_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
    assign mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a vector table for hazard/flush/freeze
// behaviour plus hand sequences for timeout, reset-in-wait and saturation.
module tb_pipeline_ctrl;

    localparam int CNT_W = 4;

    // {PC_write, IFID_write, IDEX_write, EXMEM_write, IFID_flush, IDEX_flush}
    localparam logic [5:0] DEF = 6'b111100;
    localparam logic [5:0] LU  = 6'b001101;
    localparam logic [5:0] BR  = 6'b111111;
    localparam logic [5:0] FRZ = 6'b000000;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       IFID_rs1, IFID_rs2, IDEX_rd;
    logic             IFID_use_rs2, IDEX_MemRead, EX_branch_taken, dmem_busy;
    logic             PC_write, IFID_write, IDEX_write, EXMEM_write;
    logic             IFID_flush, IDEX_flush;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic             mem_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .IFID_rs1        (IFID_rs1),
        .IFID_rs2        (IFID_rs2),
        .IFID_use_rs2    (IFID_use_rs2),
        .IDEX_rd         (IDEX_rd),
        .IDEX_MemRead    (IDEX_MemRead),
        .EX_branch_taken (EX_branch_taken),
        .dmem_busy       (dmem_busy),
        .PC_write        (PC_write),
        .IFID_write      (IFID_write),
        .IDEX_write      (IDEX_write),
        .EXMEM_write     (EXMEM_write),
        .IFID_flush      (IFID_flush),
        .IDEX_flush      (IDEX_flush),
        .ctrl_state      (ctrl_state),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count),
        .mem_timeout     (mem_timeout)
    );

    typedef struct {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       busy;
        logic [5:0] ctl;
        logic [1:0] st;
        int         stc;
        int         flc;
        logic       to;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(logic rst, logic [4:0] rs1, logic [4:0] rs2, logic use2,
                                logic [4:0] rd, logic mr, logic br, logic busy,
                                logic [5:0] ctl, logic [1:0] st, int stc, int flc, logic to);
        vec_t v;
        v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.use2 = use2; v.rd = rd; v.mr = mr;
        v.br = br; v.busy = busy; v.ctl = ctl; v.st = st; v.stc = stc; v.flc = flc; v.to = to;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic use2, input logic [4:0] rd, input logic mr,
                         input logic br, input logic busy);
        @(negedge clk);
        reset = rst; IFID_rs1 = rs1; IFID_rs2 = rs2; IFID_use_rs2 = use2;
        IDEX_rd = rd; IDEX_MemRead = mr; EX_branch_taken = br; dmem_busy = busy;
        #2;
    endtask

    function automatic logic [5:0] ctl_now();
        return {PC_write, IFID_write, IDEX_write, EXMEM_write, IFID_flush, IDEX_flush};
    endfunction

    initial begin
        // Cycle-by-cycle stream; st/stc/flc/to are the registered values seen
        // during that cycle, before its closing edge.
        vecs[0]  = mk(1, 2, 0, 0, 2, 1, 1, 1, DEF, 0, 0, 0, 0); // reset beats busy/branch/hazard
        vecs[1]  = mk(0, 2, 0, 0, 2, 1, 0, 0, LU,  0, 0, 0, 0); // load-use on rs1
        vecs[2]  = mk(0, 2, 0, 0, 2, 1, 0, 0, DEF, 1, 1, 0, 0); // LU_STALL ignores hazard
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 1, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 1, 0, 0, DEF, 0, 1, 0, 0); // rd = x0
        vecs[5]  = mk(0, 5, 2, 0, 2, 1, 0, 0, DEF, 0, 1, 0, 0); // rs2 match but unused
        vecs[6]  = mk(0, 5, 2, 1, 2, 1, 0, 0, LU,  0, 1, 0, 0); // rs2 match used
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, DEF, 1, 2, 0, 0);
        vecs[8]  = mk(0, 2, 0, 0, 2, 1, 1, 0, BR,  0, 2, 0, 0); // branch beats load-use
        vecs[9]  = mk(0, 2, 0, 0, 2, 1, 1, 0, DEF, 2, 2, 1, 0); // FLUSH ignores branch
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 2, 1, 0);
        vecs[11] = mk(1, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 2, 1, 0);
        vecs[12] = mk(0, 3, 0, 0, 3, 1, 0, 0, LU,  0, 0, 0, 0);
        vecs[13] = mk(0, 3, 0, 0, 3, 1, 0, 1, FRZ, 1, 1, 0, 0); // freeze during LU_STALL
        vecs[14] = mk(0, 3, 0, 0, 3, 1, 0, 1, FRZ, 3, 2, 0, 0);
        vecs[15] = mk(0, 3, 0, 0, 3, 1, 1, 1, FRZ, 3, 3, 0, 0);
        vecs[16] = mk(0, 3, 0, 0, 3, 1, 1, 0, DEF, 3, 4, 0, 0); // replay as LU_STALL
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 4, 0, 0);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 1, 1, FRZ, 0, 4, 0, 0); // busy beats branch
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 1, 0, BR,  3, 5, 0, 0); // replay as RUN
        vecs[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, DEF, 2, 5, 1, 0);
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, DEF, 0, 5, 1, 0);

        reset = 1'b1; IFID_rs1 = '0; IFID_rs2 = '0; IFID_use_rs2 = 1'b0;
        IDEX_rd = '0; IDEX_MemRead = 1'b0; EX_branch_taken = 1'b0; dmem_busy = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].rst, vecs[i].rs1, vecs[i].rs2, vecs[i].use2,
                  vecs[i].rd, vecs[i].mr, vecs[i].br, vecs[i].busy);
            chk($sformatf("v%0d ctl", i), int'(ctl_now()), int'(vecs[i].ctl));
            chk($sformatf("v%0d state", i), int'(ctrl_state), int'(vecs[i].st));
            chk($sformatf("v%0d stall", i), int'(stall_cycles), vecs[i].stc);
            chk($sformatf("v%0d flush", i), int'(flush_count), vecs[i].flc);
            chk($sformatf("v%0d tmo", i), int'(mem_timeout), int'(vecs[i].to));
        end

        // Timeout: 6 busy cycles with MEM_TIMEOUT=4, then release.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1);
            chk($sformatf("tmo before edge %0d", k), int'(mem_timeout), (k >= 5) ? 1 : 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("tmo after release", int'(mem_timeout), 1);
        chk("tmo stall count", int'(stall_cycles), 6);
        chk("tmo state wait", int'(ctrl_state), 3);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("tmo sticky", int'(mem_timeout), 1);
        chk("tmo state run", int'(ctrl_state), 0);

        // Reset mid-MEM_WAIT with busy still asserted.
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        chk("rst pre state", int'(ctrl_state), 3);
        drive(1, 2, 0, 0, 2, 1, 1, 1);
        chk("rst ctl", int'(ctl_now()), int'(DEF));
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst state", int'(ctrl_state), 0);
        chk("rst tmo", int'(mem_timeout), 0);
        chk("rst stall", int'(stall_cycles), 0);
        chk("rst flush", int'(flush_count), 0);
        chk("rst ctl after", int'(ctl_now()), int'(DEF));

        // Stall counter saturation.
        for (int k = 0; k < 20; k++) drive(0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("stall saturate", int'(stall_cycles), 15);

        // Flush counter saturation: branch in RUN every other cycle.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 0);
            drive(0, 0, 0, 0, 0, 0, 1, 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush saturate", int'(flush_count), 15);
        chk("flush no stall", int'(stall_cycles), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
